// File: rtl/flag_cond_unit_pkg.sv
// Shared definitions for the flag/condition unit and its sequencer clients.
// Holds the condition-code encoding and the bit positions of the flags
// inside the 4-bit {N,Z,C,V} flags word.
package flag_cond_unit_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Assemble individual ALU flags into the architectural flags word.
  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/flag_cond_unit_if.sv
// Condition request/result handshake between the sequencer (master) and
// the flag/condition unit (slave).
//   cond_valid/cond_code/cond_ready : request channel
//   res_valid/taken/res_ready       : result channel
interface flag_cond_unit_if;
  logic       cond_valid;
  logic [3:0] cond_code;
  logic       cond_ready;
  logic       res_valid;
  logic       taken;
  logic       res_ready;

  modport master (
    output cond_valid, cond_code, res_ready,
    input  cond_ready, res_valid, taken
  );

  modport slave (
    input  cond_valid, cond_code, res_ready,
    output cond_ready, res_valid, taken
  );
endinterface

// File: rtl/flag_cond_unit_cond_eval.sv
// Purely combinational condition evaluator.
//   cond_code : 4-bit condition code
//   flags     : {N,Z,C,V}
//   taken     : 1 when the condition holds for the given flags
module cond_eval
  import flag_cond_unit_pkg::*;
(
  input  logic [3:0] cond_code,
  input  logic [3:0] flags,
  output logic       taken
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond_code))
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_CS: taken = c;
      COND_CC: taken = !c;
      COND_MI: taken = n;
      COND_PL: taken = !n;
      COND_VS: taken = v;
      COND_VC: taken = !v;
      COND_HI: taken = c & !z;
      COND_LS: taken = !c | z;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = !z & (n == v);
      COND_LE: taken = z | (n != v);
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_cond_unit.sv
// Architectural flags register, condition evaluation handshake and a small
// LIFO flag save/restore stack.
//   clk, reset_n            : clock, async active-low reset
//   flag_we, c/n/z/v_in     : capture ALU flags
//   flags_out               : registered {N,Z,C,V}
//   cond_if (slave)         : condition request/result handshake
//   push, pop               : save/restore flags
//   stack_full/empty/err    : stack status, err is a one-cycle pulse
module flag_cond_unit
  import flag_cond_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flag_we,
  input  logic         c_in,
  input  logic         n_in,
  input  logic         z_in,
  input  logic         v_in,
  output logic [3:0]   flags_out,
  flag_cond_unit_if.slave cond_if,
  input  logic         push,
  input  logic         pop,
  output logic         stack_full,
  output logic         stack_empty,
  output logic         stack_err
);

  localparam logic [PTR_W:0] OCC_FULL = (PTR_W+1)'(DEPTH);

  logic [3:0]       flags_q, flags_d;
  logic [PTR_W:0]   occ;
  logic [3:0]       stk [DEPTH];
  logic [PTR_W-1:0] top_idx;
  logic             push_ok, pop_ok, err_d;
  logic             res_valid_q, taken_q, eval_taken;
  logic             cond_ready, accept;

  // ---------------- stack ----------------
  assign stack_full  = (occ == OCC_FULL);
  assign stack_empty = (occ == '0);
  // When full the low bits wrap to 0, so minus one still lands on the top.
  assign top_idx     = occ[PTR_W-1:0] - 1'b1;

  assign push_ok = push & !pop & !stack_full;
  assign pop_ok  = pop & !push & !stack_empty;
  assign err_d   = (push & pop) | (push & !pop & stack_full) |
                   (pop & !push & stack_empty);

  // Contents are don't-care after reset; only occupancy is reset.
  always_ff @(posedge clk) begin
    if (push_ok) stk[occ[PTR_W-1:0]] <= flags_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ       <= '0;
      stack_err <= 1'b0;
    end else begin
      stack_err <= err_d;
      if (push_ok)     occ <= occ + 1'b1;
      else if (pop_ok) occ <= occ - 1'b1;
    end
  end

  // ---------------- flags register ----------------
  // ALU write has priority over a restore; the pop still consumes the entry.
  always_comb begin
    flags_d = flags_q;
    if (pop_ok)  flags_d = stk[top_idx];
    if (flag_we) flags_d = pack_flags(n_in, z_in, c_in, v_in);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) flags_q <= '0;
    else          flags_q <= flags_d;
  end

  assign flags_out = flags_q;

  // ---------------- condition handshake ----------------
  cond_eval u_eval (
    .cond_code (cond_if.cond_code),
    .flags     (flags_q),
    .taken     (eval_taken)
  );

  assign cond_ready = !res_valid_q | cond_if.res_ready;
  assign accept     = cond_if.cond_valid & cond_ready;

  // Result is computed from the pre-edge flags, so a same-cycle flag_we
  // never leaks into it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid_q <= 1'b0;
      taken_q     <= 1'b0;
    end else if (accept) begin
      res_valid_q <= 1'b1;
      taken_q     <= eval_taken;
    end else if (cond_if.res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign cond_if.cond_ready = cond_ready;
  assign cond_if.res_valid  = res_valid_q;
  assign cond_if.taken      = taken_q;

endmodule

// File: doc/flag_cond_unit.md
Name: flag_cond_unit

Overview:
- Consumer end of the ALU flag path: captures the C/N/Z/V flags produced by the ALU flag logic into an architectural flags register.
- Evaluates 4-bit branch/condition codes against the registered flags through a valid/ready handshake.
- Includes a small LIFO save/restore stack so flags can be preserved across interrupts or subroutines.
- Sits between the ALU and the control/sequencer logic.

Parameters:
- DEPTH, 4, number of flag-stack entries (power of 2, ≥2).
- PTR_W, 2, log2(DEPTH); the occupancy counter is PTR_W+1 bits wide.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- flag_we  in  1  capture c_in/n_in/z_in/v_in into the flags register this cycle
- c_in  in  1  ALU carry flag
- n_in  in  1  ALU negative flag
- z_in  in  1  ALU zero flag
- v_in  in  1  ALU overflow flag
- flags_out  out  4  registered flags {N,Z,C,V}
- cond_valid  in  1  condition request valid
- cond_code  in  4  condition code to evaluate
- cond_ready  out  1  unit can accept a request
- res_valid  out  1  result valid
- taken  out  1  condition result, meaningful while res_valid=1
- res_ready  in  1  consumer accepts the result
- push  in  1  save current flags to the stack
- pop  in  1  restore flags from the stack
- stack_full  out  1  occupancy == DEPTH
- stack_empty  out  1  occupancy == 0
- stack_err  out  1  one-cycle pulse on an illegal stack operation

Behaviour:
- Reset (asynchronous, reset_n=0) forces:
  - flags_out=4'b0000, res_valid=0, taken=0, stack_err=0.
  - Occupancy=0, so stack_empty=1 and stack_full=0.
  - Stack contents: don't-care.
- Reset asserted mid-handshake drops any pending result; no result is produced after release.
- Flags register:
  - On a clk edge with flag_we=1, flags_out <= {n_in,z_in,c_in,v_in}; visible the next cycle.
- Condition table, evaluated on the registered flags:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V
  - C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0
- Handshake:
  - cond_ready = !res_valid | res_ready (combinational).
  - A request is accepted when cond_valid & cond_ready.
  - The next cycle res_valid=1 and taken holds the result computed from flags_out as it was in the accept cycle. A flag_we in that same cycle does not affect the result.
  - Latency is 1 cycle; throughput is 1 per cycle while res_ready=1.
  - res_valid and taken hold stable until res_valid & res_ready.
  - If the result is consumed and there is no new accept, res_valid <= 0.
- Stack:
  - Push (push=1, pop=0, not full): writes the pre-update flags_out at the top and increments occupancy.
  - Pop (pop=1, push=0, not empty): decrements occupancy and loads the top entry into flags_out.
  - Push when full, pop when empty, or push&pop together: no state change; stack_err=1 for the next cycle only.
- Simultaneous events:
  - pop with flag_we: flag_we data wins for flags_out, and the stack still pops.
  - push with flag_we: the old flags are pushed, and the new flags are loaded.
- Occupancy saturates at 0..DEPTH and never wraps.

Decomposition:
- Shared package/include holds:
  - Condition-code constants COND_EQ..COND_NV.
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One combinational sub-module, cond_eval (cond_code, flags → taken), reused by the sequencer.
- Stack and handshake logic stay in the top module.

Test Plan:
1. Reset, then flag_we with n=0,z=1,c=0,v=0 → flags_out=4'b0100; request EQ → taken=1 one cycle after accept; request NE → taken=0.
2. flags {N=1,V=0}: request GE → taken=0, LT → taken=1; flags {N=1,V=1,Z=0}: GT → 1; request AL → 1 and NV → 0 under any flags.
3. Hold res_ready=0 for 3 cycles after an accept → res_valid/taken stable, cond_ready=0, no new accept; then res_ready=1 with back-to-back requests → one result per cycle.
4. Stack fill/drain:
   - Push 4 distinct flag values (0001, 0010, 0100, 1000) → stack_full=1.
   - A 5th push → stack_err pulse and no change.
   - 4 pops → flags restore 1000, 0100, 0010, 0001 in order, then stack_empty=1.
   - A further pop → stack_err pulse.
5. Same-cycle flag_we=1 (new flags 1111) with an accept of EQ while flags_out=0000 → taken=0 (old flags) and flags_out=1111 afterward; push+flag_we → the popped value later equals the old flags.
6. Assert reset_n=0 asynchronously between an accept and its result → res_valid=0 immediately, flags_out=0000, stack_empty=1, no result after release.
